framebuffer_stream_receiver: RTL and testbench
==============================================

// Module: framebuffer_stream_receiver
// PURPOSE
//  Sink end of the rasterizer framebuffer AXI-Stream. Accepts colour-buffer beats
//  (one subpart of Y_LINE_RESOLUTION rows per tlast-terminated packet) and unpacks
//  them into a per-pixel stream with x/y coordinates and frame markers for the
//  display/scanout path. Checks tlast framing and flags errors.
// PARAMETERS
//  X_RESOLUTION              128            screen width in pixels
//  Y_RESOLUTION              128            screen height in pixels
//  Y_LINE_RESOLUTION         Y_RESOLUTION   rows per subpart; must divide Y_RESOLUTION
//  FRAMEBUFFER_STREAM_WIDTH  16             beat width; multiple of 16, max 256
// PORTS
//  aclk                       in   1     clock
//  resetn                     in   1     asynchronous reset, active low
//  s_framebuffer_axis_tvalid  in   1     beat valid
//  s_framebuffer_axis_tready  out  1     beat accepted
//  s_framebuffer_axis_tlast   in   1     last beat of a subpart
//  s_framebuffer_axis_tdata   in   FSW   packed RGB565 pixels, pixel 0 in bits [15:0]
//  m_pixel_valid              out  1     pixel valid
//  m_pixel_ready              in   1     downstream accepts pixel
//  m_pixel_data               out  16    RGB565 pixel
//  m_pixel_x                  out  clog2(X_RESOLUTION)  column
//  m_pixel_y                  out  clog2(Y_RESOLUTION)  row
//  m_pixel_sof                out  1     pixel at (0,0)
//  m_pixel_eol                out  1     pixel at x = X_RESOLUTION-1
//  frame_done                 out  1     one-cycle pulse after handshake of (X-1,Y-1)
//  err_tlast_early            out  1     sticky: tlast before subpart end
//  err_tlast_missing          out  1     sticky: subpart end without tlast
//  clear_errors               in   1     synchronous clear of both sticky flags
// BEHAVIOUR
//  - Reset: tready=0 during reset, 1 in the first cycle after. m_pixel_valid=0, x=y=0,
//    sof/eol/frame_done=0, both error flags=0, holding register empty.
//  - PPB = FRAMEBUFFER_STREAM_WIDTH/16. One holding register plus pixel index idx.
//  - Handshake: tready = !held || (idx==PPB-1 && m_pixel_ready). This allows back-to-back
//    beats at 1 pixel/clk when PPB=1. A beat is accepted on tvalid&&tready. Its first
//    pixel is valid on the next cycle (latency 1).
//  - m_pixel_valid = held. m_pixel_data, x, y, sof and eol stay stable while
//    valid && !ready (AXI rule).
//  - States:
//    - EMPTY: holding register empty.
//    - UNPACK: emitting pixels idx = 0..PPB-1.
//    - UNPACK -> EMPTY: after the last pixel handshake with no new beat.
//    - UNPACK -> UNPACK: after the last pixel handshake when a new beat is accepted
//      in the same cycle.
//  - Position update on every pixel handshake:
//    - x increments; at X-1 it wraps to 0 and y increments.
//    - At (X-1, Y-1) both wrap to 0, and frame_done pulses on the next cycle.
//  - A subpart ends at the pixel with x=X-1 and (y+1) % Y_LINE_RESOLUTION == 0.
//    expect_last = the current beat holds the subpart-end pixel.
//  - Error flag set has priority over clear_errors in the same cycle.
// CONFIGURATION
//  FB_RX_TLAST_CHECK_EN defined:
//   - tlast on a beat with !expect_last sets err_tlast_early. The beat's pixels are
//     emitted normally. After its last pixel, x=0 and y jumps to the start of the next
//     subpart, wrapping to 0 after the last subpart.
//   - A beat with expect_last and !tlast sets err_tlast_missing. Counting continues
//     unmodified.
//  FB_RX_TLAST_CHECK_EN undefined:
//   - tlast is ignored, positions are pure counters, both error flags are tied to 0.
// STRUCTURE
//  - Shared package fb_rx_pkg holds:
//    - state encoding (EMPTY, UNPACK)
//    - PIXEL_WIDTH = 16
//    - RGB565 field positions
//    - function computing PPB
//  - Sub-module fb_rx_unpacker holds the holding register, idx counter and tready logic.
//    The top keeps the position counters, framing checks and flags.
// TESTING
//  - Reset: X=4, Y=4, YL=2, FSW=16. Drive resetn=0 mid-frame. Expect valid=0, x=y=0,
//    flags=0. The first pixel after reset has sof=1.
//  - Full frame: FSW=64, X=4, Y=4, YL=2. Send 4 beats with tlast on beats 2 and 4.
//    Expect 16 pixels in order 0x0000..0x000F, eol on every 4th pixel,
//    frame_done pulse one cycle after pixel 15, no errors.
//  - Backpressure: m_pixel_ready toggles 1,0,0,1. Expect data/x/y held while stalled,
//    tready=0 until the last pixel of the beat handshakes, no pixel lost or duplicated.
//  - Early tlast (CHECK_EN): X=4, YL=2, FSW=16. Set tlast on the 3rd pixel.
//    Expect err_tlast_early=1, next pixel at (0,2). clear_errors then returns the flag to 0.
//  - Missing tlast (CHECK_EN): omit tlast on pixel 7 of subpart 0.
//    Expect err_tlast_missing=1, next pixel at (0,2).
//    With the macro undefined, the same stimulus leaves both flags at 0.
//  - Throughput: FSW=16, ready held at 1, tvalid continuous for 16 pixels.
//    Expect tready=1 every cycle and 16 pixels in 16 consecutive cycles.

Source files
------------

// File: rtl/fb_rx_pkg.sv
// fb_rx_pkg: shared types and helpers for the framebuffer stream receiver.
package fb_rx_pkg;
    typedef enum logic {EMPTY, UNPACK} state_e;
    localparam int PIXEL_WIDTH = 16;
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;
    function automatic int fb_ppb(input int fsw);
        return fsw / PIXEL_WIDTH;
    endfunction
endpackage

// File: rtl/fb_rx_unpacker.sv
// fb_rx_unpacker: holds one accepted beat and emits its RGB565 pixels one per handshake.
module fb_rx_unpacker
    import fb_rx_pkg::*;
#(
    parameter int FSW = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s_tvalid_i,
    output logic                   s_tready_o,
    input  logic                   s_tlast_i,
    input  logic [FSW-1:0]         s_tdata_i,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic [PIXEL_WIDTH-1:0] pix_data_o,
    output logic                   pix_last_o,
    output logic                   beat_tlast_o
);
    localparam int PPB = fb_ppb(FSW);
    localparam int IW  = PPB > 1 ? $clog2(PPB) : 1;

    state_e         state_q, state_d;
    logic [FSW-1:0] data_q, data_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           tlast_q, tlast_d;
    logic           accept, hs;
    rgb565_t        pix;

    // Refilling while the final pixel leaves keeps PPB=1 streams at one pixel per clock.
    assign pix_last_o   = idx_q == IW'(PPB - 1);
    assign s_tready_o   = rst_ni && (state_q == EMPTY || (pix_last_o && pix_ready_i));
    assign accept       = s_tvalid_i && s_tready_o;
    assign hs           = state_q == UNPACK && pix_ready_i;
    assign pix          = data_q[int'(idx_q) * PIXEL_WIDTH +: PIXEL_WIDTH];
    assign pix_data_o   = pix;
    assign pix_valid_o  = state_q == UNPACK;
    assign beat_tlast_o = tlast_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        tlast_d = tlast_q;
        if (accept) begin
            state_d = UNPACK;
            data_d  = s_tdata_i;
            idx_d   = '0;
            tlast_d = s_tlast_i;
        end else if (hs) begin
            state_d = pix_last_o ? EMPTY : UNPACK;
            idx_d   = pix_last_o ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            data_q  <= '0;
            idx_q   <= '0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            tlast_q <= tlast_d;
        end
    end
endmodule

// File: rtl/framebuffer_stream_receiver.sv
// framebuffer_stream_receiver: unpacks framebuffer AXI-Stream beats into an x/y pixel stream.
// Define FB_RX_TLAST_CHECK_EN to enable tlast framing checks and subpart resynchronisation.
module framebuffer_stream_receiver
    import fb_rx_pkg::*;
#(
    parameter int X_RESOLUTION             = 128,
    parameter int Y_RESOLUTION             = 128,
    parameter int Y_LINE_RESOLUTION        = Y_RESOLUTION,
    parameter int FRAMEBUFFER_STREAM_WIDTH = 16
) (
    input  logic                                aclk,
    input  logic                                resetn,
    input  logic                                s_framebuffer_axis_tvalid,
    output logic                                s_framebuffer_axis_tready,
    input  logic                                s_framebuffer_axis_tlast,
    input  logic [FRAMEBUFFER_STREAM_WIDTH-1:0] s_framebuffer_axis_tdata,
    output logic                                m_pixel_valid,
    input  logic                                m_pixel_ready,
    output logic [PIXEL_WIDTH-1:0]              m_pixel_data,
    output logic [$clog2(X_RESOLUTION)-1:0]     m_pixel_x,
    output logic [$clog2(Y_RESOLUTION)-1:0]     m_pixel_y,
    output logic                                m_pixel_sof,
    output logic                                m_pixel_eol,
    output logic                                frame_done,
    output logic                                err_tlast_early,
    output logic                                err_tlast_missing,
    input  logic                                clear_errors
);
    localparam int XW = $clog2(X_RESOLUTION);
    localparam int YW = $clog2(Y_RESOLUTION);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          fd_q, ee_q, em_q;
    logic          pix_last, beat_tlast, hs, x_end, y_end, expect_last, set_e, set_m;
    int            ns_y;

    fb_rx_unpacker #(.FSW(FRAMEBUFFER_STREAM_WIDTH)) u_unpacker (
        .clk_i        (aclk),
        .rst_ni       (resetn),
        .s_tvalid_i   (s_framebuffer_axis_tvalid),
        .s_tready_o   (s_framebuffer_axis_tready),
        .s_tlast_i    (s_framebuffer_axis_tlast),
        .s_tdata_i    (s_framebuffer_axis_tdata),
        .pix_valid_o  (m_pixel_valid),
        .pix_ready_i  (m_pixel_ready),
        .pix_data_o   (m_pixel_data),
        .pix_last_o   (pix_last),
        .beat_tlast_o (beat_tlast)
    );

    assign hs          = m_pixel_valid && m_pixel_ready;
    assign x_end       = x_q == XW'(X_RESOLUTION - 1);
    assign y_end       = y_q == YW'(Y_RESOLUTION - 1);
    assign expect_last = x_end && ((int'(y_q) + 1) % Y_LINE_RESOLUTION == 0);
    assign ns_y        = int'(y_q) - int'(y_q) % Y_LINE_RESOLUTION + Y_LINE_RESOLUTION;

`ifdef FB_RX_TLAST_CHECK_EN
    // Framing is judged on the beat's final pixel, where the subpart end must sit.
    assign set_e = hs && pix_last && beat_tlast && !expect_last;
    assign set_m = hs && pix_last && !beat_tlast && expect_last;
`else
    logic unused_framing;
    assign unused_framing = pix_last ^ beat_tlast ^ expect_last;
    assign set_e = 1'b0;
    assign set_m = 1'b0;
`endif

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (hs) begin
            x_d = (set_e || x_end) ? '0 : x_q + XW'(1);
            y_d = set_e ? (ns_y >= Y_RESOLUTION ? '0 : YW'(ns_y))
                : x_end ? (y_end ? '0 : y_q + YW'(1)) : y_q;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            x_q  <= '0;
            y_q  <= '0;
            fd_q <= 1'b0;
            ee_q <= 1'b0;
            em_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fd_q <= hs && x_end && y_end;
            ee_q <= set_e || (ee_q && !clear_errors);
            em_q <= set_m || (em_q && !clear_errors);
        end
    end

    assign m_pixel_x         = x_q;
    assign m_pixel_y         = y_q;
    assign m_pixel_sof       = m_pixel_valid && x_q == '0 && y_q == '0;
    assign m_pixel_eol       = m_pixel_valid && x_end;
    assign frame_done        = fd_q;
    assign err_tlast_early   = ee_q;
    assign err_tlast_missing = em_q;
endmodule

// File: tb/tb_framebuffer_stream_receiver.sv
// tb_framebuffer_stream_receiver: scoreboard bench driving a 16-bit and a 64-bit receiver (X=Y=4, YL=2).
module tb_framebuffer_stream_receiver;
    localparam int X = 4, Y = 4, YL = 2;
`ifdef FB_RX_TLAST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        logic        sof;
        logic        eol;
    } exp_t;
    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic clk = 1'b0, resetn = 1'b0, clear_errors = 1'b0;
    always #5 clk = ~clk;

    logic        a_tv, a_tr, a_tl, a_pv, a_pr, a_sof, a_eol, a_fd, a_ee, a_em;
    logic [15:0] a_td, a_pd;
    logic [1:0]  a_x, a_y;
    logic        b_tv, b_tr, b_tl, b_pv, b_pr, b_sof, b_eol, b_fd, b_ee, b_em;
    logic [63:0] b_td;
    logic [15:0] b_pd;
    logic [1:0]  b_x, b_y;

    framebuffer_stream_receiver #(.X_RESOLUTION(X), .Y_RESOLUTION(Y), .Y_LINE_RESOLUTION(YL),
                                  .FRAMEBUFFER_STREAM_WIDTH(16)) dut_a (
        .aclk(clk), .resetn(resetn),
        .s_framebuffer_axis_tvalid(a_tv), .s_framebuffer_axis_tready(a_tr),
        .s_framebuffer_axis_tlast(a_tl), .s_framebuffer_axis_tdata(a_td),
        .m_pixel_valid(a_pv), .m_pixel_ready(a_pr), .m_pixel_data(a_pd),
        .m_pixel_x(a_x), .m_pixel_y(a_y), .m_pixel_sof(a_sof), .m_pixel_eol(a_eol),
        .frame_done(a_fd), .err_tlast_early(a_ee), .err_tlast_missing(a_em),
        .clear_errors(clear_errors)
    );

    framebuffer_stream_receiver #(.X_RESOLUTION(X), .Y_RESOLUTION(Y), .Y_LINE_RESOLUTION(YL),
                                  .FRAMEBUFFER_STREAM_WIDTH(64)) dut_b (
        .aclk(clk), .resetn(resetn),
        .s_framebuffer_axis_tvalid(b_tv), .s_framebuffer_axis_tready(b_tr),
        .s_framebuffer_axis_tlast(b_tl), .s_framebuffer_axis_tdata(b_td),
        .m_pixel_valid(b_pv), .m_pixel_ready(b_pr), .m_pixel_data(b_pd),
        .m_pixel_x(b_x), .m_pixel_y(b_y), .m_pixel_sof(b_sof), .m_pixel_eol(b_eol),
        .frame_done(b_fd), .err_tlast_early(b_ee), .err_tlast_missing(b_em),
        .clear_errors(clear_errors)
    );

    exp_t  qa[$], qb[$];
    beat_t ba[$], bb[$];
    int    mx[2], my[2], pend[2];
    bit    ee[2], em[2], fdx[2];
    bit    b_bp;
    int    n_chk, n_pass, cyc, hs_n, hs_first, hs_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int ppb(input int i);
        return i == 0 ? 1 : 4;
    endfunction

    function automatic logic [63:0] pack4(input int base);
        return {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
    endfunction

    // Reference position model: plain raster counting, plus subpart resync on early tlast.
    task automatic send(input int i, input logic [63:0] d, input logic l);
        exp_t  e;
        beat_t b;
        bit    xl, lastp;
        b.d = d;
        b.l = l;
        if (i == 0) ba.push_back(b); else bb.push_back(b);
        for (int p = 0; p < ppb(i); p++) begin
            e.d   = d[16*p +: 16];
            e.x   = mx[i];
            e.y   = my[i];
            e.sof = mx[i] == 0 && my[i] == 0;
            e.eol = mx[i] == X - 1;
            if (i == 0) qa.push_back(e); else qb.push_back(e);
            xl    = mx[i] == X - 1 && my[i] % YL == YL - 1;
            lastp = p == ppb(i) - 1;
            if (CHK && lastp && l && !xl) begin
                ee[i] = 1'b1;
                mx[i] = 0;
                my[i] = (my[i] / YL + 1) * YL;
                if (my[i] >= Y) my[i] = 0;
            end else begin
                if (CHK && lastp && !l && xl) em[i] = 1'b1;
                mx[i]++;
                if (mx[i] == X) begin
                    mx[i] = 0;
                    my[i] = (my[i] + 1) % Y;
                end
            end
        end
    endtask

    task automatic align();
        int v = 'h500;
        while (mx[0] != 0 || my[0] != 0) begin
            send(0, 64'(v), mx[0] == X - 1 && my[0] % YL == YL - 1);
            v++;
        end
    endtask

    task automatic obs(input int i, input logic pv, input logic pr, input logic [15:0] pd,
                       input logic [1:0] x, input logic [1:0] y, input logic sof, input logic eol,
                       input logic fd, input logic tv, input logic tr);
        exp_t  e;
        string p = i == 0 ? "a." : "b.";
        int    n = i == 0 ? qa.size() : qb.size();
        chk({p, "frame_done"}, fd, fdx[i]);
        fdx[i] = 1'b0;
        chk({p, "tready"}, tr, pend[i] == 0 || (pend[i] == 1 && pr));
        chk({p, "valid"}, pv, pend[i] != 0);
        if (pv && n > 0) begin
            e = i == 0 ? qa[0] : qb[0];
            chk({p, "data"}, pd, e.d);
            chk({p, "x"}, x, e.x);
            chk({p, "y"}, y, e.y);
            chk({p, "sof"}, sof, e.sof);
            chk({p, "eol"}, eol, e.eol);
            if (pr) begin
                if (i == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                pend[i]--;
                fdx[i] = e.x == X - 1 && e.y == Y - 1;
                if (i == 0) begin
                    hs_n++;
                    if (hs_first < 0) hs_first = cyc;
                    hs_last = cyc;
                end
            end
        end
        if (tv && tr) begin
            pend[i] += ppb(i);
            if (i == 0) void'(ba.pop_front()); else void'(bb.pop_front());
        end
    endtask

    task automatic step();
        a_tv = ba.size() > 0;
        a_td = a_tv ? ba[0].d[15:0] : '0;
        a_tl = a_tv && ba[0].l;
        b_tv = bb.size() > 0;
        b_td = b_tv ? bb[0].d : '0;
        b_tl = b_tv && bb[0].l;
        a_pr = 1'b1;
        b_pr = b_bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
        #1;
        if (resetn) begin
            obs(0, a_pv, a_pr, a_pd, a_x, a_y, a_sof, a_eol, a_fd, a_tv, a_tr);
            obs(1, b_pv, b_pr, b_pd, b_x, b_y, b_sof, b_eol, b_fd, b_tv, b_tr);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (qa.size() + qb.size() + ba.size() + bb.size() != 0 && t < 400) begin
            step();
            t++;
        end
        chk("drain_pending", qa.size() + qb.size() + ba.size() + bb.size(), 0);
        repeat (3) step();
    endtask

    task automatic chk_flags();
        chk("a.err_early", a_ee, ee[0]);
        chk("a.err_missing", a_em, em[0]);
        chk("b.err_early", b_ee, ee[1]);
        chk("b.err_missing", b_em, em[1]);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        a_tv = 1'b0;
        b_tv = 1'b0;
        #1;
        chk("rst.a_tready", a_tr, 0);
        chk("rst.b_tready", b_tr, 0);
        chk("rst.a_valid", a_pv, 0);
        chk("rst.b_valid", b_pv, 0);
        chk("rst.a_xy", {a_x, a_y}, 0);
        chk("rst.b_xy", {b_x, b_y}, 0);
        chk("rst.a_marks", {a_sof, a_eol, a_fd}, 0);
        chk("rst.a_flags", {a_ee, a_em}, 0);
        chk("rst.b_flags", {b_ee, b_em}, 0);
        qa.delete(); qb.delete(); ba.delete(); bb.delete();
        for (int i = 0; i < 2; i++) begin
            mx[i] = 0; my[i] = 0; pend[i] = 0;
            ee[i] = 1'b0; em[i] = 1'b0; fdx[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; b_bp = 1'b0;
        hs_n = 0; hs_first = -1; hs_last = 0;
        a_tv = 1'b0; a_tl = 1'b0; a_td = '0; a_pr = 1'b1;
        b_tv = 1'b0; b_tl = 1'b0; b_td = '0; b_pr = 1'b1;
        @(negedge clk);
        do_reset();

        for (int j = 0; j < 4; j++) send(1, pack4(4 * j), j == 1 || j == 3);
        drain();
        chk_flags();

        b_bp = 1'b1;
        for (int j = 0; j < 4; j++) send(1, pack4('h20 + 4 * j), j == 1 || j == 3);
        drain();
        b_bp = 1'b0;
        chk_flags();

        hs_n = 0; hs_first = -1;
        for (int k = 0; k < 16; k++) send(0, 64'('h40 + k), k == 7 || k == 15);
        drain();
        chk("tput.count", hs_n, 16);
        chk("tput.span", hs_last - hs_first + 1, 16);

        for (int k = 0; k < 3; k++) send(0, 64'('h100 + k), k == 2);
        align();
        drain();
        chk_flags();
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        ee[0] = 1'b0; em[0] = 1'b0;
        step();
        chk_flags();

        for (int k = 0; k < 8; k++) send(0, 64'('h200 + k), 1'b0);
        align();
        drain();
        chk_flags();

        for (int k = 0; k < 8; k++) send(0, 64'('h300 + k), k == 7);
        repeat (4) step();
        do_reset();
        chk_flags();
        for (int k = 0; k < 16; k++) send(0, 64'('h400 + k), k == 7 || k == 15);
        drain();
        chk_flags();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
